ps2_key_decoder: RTL and testbench

//  PS/2 keyboard front end feeding the game core's left/up/right move inputs.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 152 +++++++++++++++
 rtl/ps2_key_decoder.sv | 95 +++++++++
 tb/tb_ps2_key_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants and frame-state encoding for the PS/2 front end.
// Imported by ps2_frame_rx and ps2_key_decoder.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 deframer: sync, keyClock glitch filter, fall strobe, frame FSM, timeout.
// Parity enforcement is built in only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_err
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_parity;
    frame_state_t  r_state;
    frame_state_t  w_state_nxt;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;
    logic w_par_ok;
    logic w_timeout;
    logic w_byte_ok;
    logic w_err;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];
    assign w_fall  = r_filt_d & ~r_filt;

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_parity};
`else
    // parity bit is still captured, but never rejects a frame here
    assign w_par_ok = ^{r_shift, r_parity} | 1'b1;
`endif

    assign w_timeout = (r_state != ST_IDLE) && (r_tcnt == TMAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (w_clk_s == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FMAX) begin
                r_filt <= w_clk_s;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tcnt <= '0;
        end else if (w_fall) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TMAX) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // a fall wins over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_dat_s) w_state_nxt = ST_DATA;
                    else          w_err = 1'b1;
                end
                ST_DATA: begin
                    if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_dat_s && w_par_ok) w_byte_ok = 1'b1;
                    else                     w_err = 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_parity <= 1'b0;
        end else if (w_fall) begin
            if (r_state == ST_IDLE) begin
                r_bitcnt <= '0;
            end else if (r_state == ST_DATA) begin
                r_shift  <= {w_dat_s, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end else if (r_state == ST_PARITY) begin
                r_parity <= w_dat_s;
            end
        end
    end

    assign o_byte    = r_shift;
    assign o_byte_ok = w_byte_ok;
    assign o_err     = w_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: make/break decode into held left/up/right levels.
// Build with PS2_PARITY_CHECK_EN defined to reject frames with bad parity.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       keyClock,
    input  logic       keyData,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       left,
    output logic       up,
    output logic       right,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_ok;
    logic       w_err;
    logic [8:0] w_key;
    logic       w_hit_l;
    logic       w_hit_u;
    logic       w_hit_r;

    logic [7:0] r_code;
    logic       r_valid;
    logic       r_err;
    logic       r_left;
    logic       r_up;
    logic       r_right;
    logic       r_brk;
    logic       r_ext;

    ps2_frame_rx #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) u_rx (
        .i_clk     (sysclk),
        .i_rst     (rst),
        .i_ps2_clk (keyClock),
        .i_ps2_data(keyData),
        .o_byte    (w_byte),
        .o_byte_ok (w_byte_ok),
        .o_err     (w_err)
    );

    assign w_key   = {r_ext, w_byte};
    assign w_hit_l = (w_key == {1'b0, SC_A}) || (w_key == {1'b1, SC_LEFT});
    assign w_hit_u = (w_key == {1'b0, SC_W}) || (w_key == {1'b1, SC_UP});
    assign w_hit_r = (w_key == {1'b0, SC_D}) || (w_key == {1'b1, SC_RIGHT});

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_code  <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_left  <= 1'b0;
            r_up    <= 1'b0;
            r_right <= 1'b0;
            r_brk   <= 1'b0;
            r_ext   <= 1'b0;
        end else begin
            r_valid <= w_byte_ok;
            r_err   <= w_err;
            if (w_byte_ok) begin
                r_code <= w_byte;
                if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    if (w_hit_l) r_left  <= ~r_brk;
                    if (w_hit_u) r_up    <= ~r_brk;
                    if (w_hit_r) r_right <= ~r_brk;
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign code       = r_code;
    assign code_valid = r_valid;
    assign frame_err  = r_err;
    assign left       = r_left;
    assign up         = r_up;
    assign right      = r_right;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed + random PS/2 frames
// checked against a key-state model; monitor pops on code_valid/frame_err.
module tb_ps2_key_decoder;

    localparam int CLK_HZ  = 2_000_000;
    localparam int FLEN    = 8;
    localparam int TO_US   = 50;
    localparam int TO_CYC  = (CLK_HZ / 1_000_000) * TO_US;
    localparam int HALF    = 20;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [12:0] v;
    } exp_t;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       keyClock;
    logic       keyData;
    logic [7:0] code;
    logic       code_valid;
    logic       left;
    logic       up;
    logic       right;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    bit         m_held[3];
    bit         m_brk;
    bit         m_ext;
    logic [7:0] m_code;

    ps2_key_decoder #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FLEN),
        .TIMEOUT_US(TO_US)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .keyClock  (keyClock),
        .keyData   (keyData),
        .code      (code),
        .code_valid(code_valid),
        .left      (left),
        .up        (up),
        .right     (right),
        .frame_err (frame_err)
    );

    always #5 sysclk = ~sysclk;

    function automatic int key_of(input bit ext, input logic [7:0] b);
        if (!ext && b == 8'h1C) return 0;
        if (ext && b == 8'h6B)  return 0;
        if (!ext && b == 8'h1D) return 1;
        if (ext && b == 8'h75)  return 1;
        if (!ext && b == 8'h23) return 2;
        if (ext && b == 8'h74)  return 2;
        return -1;
    endfunction

    function automatic logic [12:0] pack(input bit err, input bit vld,
                                         input logic [7:0] c,
                                         input bit l, input bit u,
                                         input bit r);
        return {err, vld, c, l, u, r};
    endfunction

    task automatic model_clear();
        m_held = '{0, 0, 0};
        m_brk  = 0;
        m_ext  = 0;
        m_code = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        exp_t e;
        int k;
        if (good) begin
            m_code = b;
            if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else begin
                k = key_of(m_ext, b);
                if (k >= 0) m_held[k] = !m_brk;
                m_brk = 0;
                m_ext = 0;
            end
        end
        e.v = pack(!good, good, m_code, m_held[0], m_held[1], m_held[2]);
        sb.push_back(e);
    endtask

    task automatic model_err();
        exp_t e;
        e.v = pack(1, 0, m_code, m_held[0], m_held[1], m_held[2]);
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            keyData = bits[i];
            wait_cyc(HALF);
            keyClock = 1'b0;
            wait_cyc(HALF);
            keyClock = 1'b1;
        end
        keyData = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        model_frame(b, !bad_stop && (!bad_par || !PCHK));
        send_bits({~bad_stop, p, b, 1'b0}, 11);
        wait_cyc(2 * HALF);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [12:0] got;
        forever begin
            @(negedge sysclk);
            if (rst !== 1'b0) continue;
            if (code_valid || frame_err) begin
                got = pack(frame_err, code_valid, code, left, up, right);
                if (sb.size() == 0) begin
                    check("unexpected_event", {19'd0, got}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("event", {19'd0, got}, {19'd0, e.v});
                end
            end
        end
    end

    logic [7:0] pool[10];

    initial begin
        pool = '{8'h1C, 8'h1D, 8'h23, 8'h6B, 8'h75,
                 8'h74, 8'hF0, 8'hE0, 8'hAA, 8'h00};
        model_clear();
        rst      = 1'b1;
        keyClock = 1'b1;
        keyData  = 1'b1;
        wait_cyc(5);
        check("reset_outs",
              {19'd0, pack(frame_err, code_valid, code, left, up, right)},
              32'd0);
        rst = 1'b0;
        wait_cyc(20);

        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);

        send_frame(8'h1D, 0, 0);
        send_frame(8'h23, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);

        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h75, 0, 0);

        send_frame(8'h1C, 1, 0);
        send_frame(8'h6B, 0, 1);

        model_err();
        send_bits({5'b10110, 1'b0}, 6);
        wait_cyc(3 * TO_CYC);
        send_frame(8'h23, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                keyClock = 1'b0;
                wait_cyc($urandom_range(1, FLEN - 3));
                keyClock = 1'b1;
                wait_cyc(HALF);
            end
            send_frame(b, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 11) == 0);
        end

        send_frame(8'h1C, 0, 0);
        send_frame(8'h1D, 0, 0);
        wait_cyc(50);
        check("sb_drained_pre_rst", sb.size(), 0);
        send_bits({4'b1101, 1'b0}, 5);
        rst = 1'b1;
        model_clear();
        #1;
        check("midframe_rst_outs",
              {19'd0, pack(frame_err, code_valid, code, left, up, right)},
              32'd0);
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(20);
        send_frame(8'h23, 0, 0);
        wait_cyc(50);
        check("right_after_rst", {29'd0, left, up, right}, 32'd1);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
